// File: rtl/comparador_pkg.sv
// Shared constants and types for the masked symbol matcher.
package comparador_pkg;

   localparam int WIDTH_DEF   = 5;
   localparam int ENTRIES_DEF = 8;
   localparam int CNT_W_DEF   = 16;

   localparam logic [WIDTH_DEF-1:0] MASK_RST = '1;

   // Table entry at the default symbol width
   typedef struct packed {
      logic                 en;
      logic [WIDTH_DEF-1:0] pattern;
      logic [WIDTH_DEF-1:0] mask;
   } entrada_t;

endpackage

// File: rtl/comparador_mascara.sv
// Masked equality of one pattern table entry against the incoming symbol.
module comparador_mascara #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] pattern,
   input  logic [WIDTH-1:0] mask,
   input  logic             en,
   output logic             match
);

   assign match = en & (((data ^ pattern) & mask) == '0);

endmodule

// File: rtl/comparador_patrones.sv
// Two-stage symbol matcher: programmable masked pattern table, lowest-index
// priority result, multi-match flag and a saturating hit counter.
module comparador_patrones
   import comparador_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic             cfg_en,
   input  logic [WIDTH-1:0] cfg_pattern,
   input  logic [WIDTH-1:0] cfg_mask,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_hit,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_multi,
   input  logic             clr_count,
   output logic [CNT_W-1:0] hit_count
);

   typedef struct packed {
      logic             en;
      logic [WIDTH-1:0] pattern;
      logic [WIDTH-1:0] mask;
   } tabla_t;

   tabla_t             tabla [ENTRIES];
   logic [ENTRIES-1:0] match;
   logic [ENTRIES-1:0] s1_match;
   logic               s1_valid;
   logic               adv2;
   logic               load1;
   logic               p_hit;
   logic [IDX_W-1:0]   p_idx;
   logic               p_multi;

   // Out-of-range cfg_idx never equals any generated index, so it is dropped.
   for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            tabla[i].en      <= 1'b0;
            tabla[i].pattern <= '0;
            tabla[i].mask    <= '1;
         end else if (cfg_we && (cfg_idx == IDX_W'(i))) begin
            tabla[i].en      <= cfg_en;
            tabla[i].pattern <= cfg_pattern;
            tabla[i].mask    <= cfg_mask;
         end
      end

      comparador_mascara #(.WIDTH(WIDTH)) u_mascara (
         .data    (in_data),
         .pattern (tabla[i].pattern),
         .mask    (tabla[i].mask),
         .en      (tabla[i].en),
         .match   (match[i])
      );
   end

   assign adv2     = s1_valid & (~out_valid | out_ready);
   assign load1    = ~s1_valid | adv2;
   assign in_ready = load1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_match <= '0;
      end else if (load1) begin
         s1_valid <= in_valid;
         if (in_valid) s1_match <= match;
      end
   end

   // Descending scan so the lowest set index wins.
   always_comb begin
      p_hit = 1'b0;
      p_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (s1_match[i]) begin
            p_hit = 1'b1;
            p_idx = IDX_W'(i);
         end
      end
      p_multi = |(s1_match & (s1_match - ENTRIES'(1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_hit   <= 1'b0;
         out_idx   <= '0;
         out_multi <= 1'b0;
      end else if (adv2) begin
         out_valid <= 1'b1;
         out_hit   <= p_hit;
         out_idx   <= p_idx;
         out_multi <= p_multi;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count <= '0;
      end else if (clr_count) begin
         hit_count <= '0;
      end else if (out_valid && out_ready && out_hit && (hit_count != '1)) begin
         hit_count <= hit_count + CNT_W'(1);
      end
   end

endmodule
